// File: rtl/egress_scheduler_if.sv
// Egress scheduler bus bundle: the four destination-FIFO read ports on one side
// and the single valid/ready egress port on the other.
// The master modport is the scheduler; the slave modport is its environment
// (the FIFOs plus the downstream consumer).
interface egress_scheduler_if #(
    parameter int TAMANO_DATOS = 12
);
    logic [3:0]                  empty;
    logic [3:0]                  almost_empty;
    logic [4*TAMANO_DATOS-1:0]   fifo_data;
    logic [3:0]                  pop;
    logic                        out_ready;
    logic                        out_valid;
    logic [TAMANO_DATOS-1:0]     data_out;
    logic [1:0]                  out_lane;

    modport master (
        input  empty,
        input  almost_empty,
        input  fifo_data,
        input  out_ready,
        output pop,
        output out_valid,
        output data_out,
        output out_lane
    );

    modport slave (
        output empty,
        output almost_empty,
        output fifo_data,
        output out_ready,
        input  pop,
        input  out_valid,
        input  data_out,
        input  out_lane
    );
endinterface

// File: rtl/egress_scheduler.sv
// Egress scheduler: drains fifo4..fifo7 with burst-limited round-robin into a
// 2-entry skid buffer that feeds one valid/ready egress port, and keeps a
// wrapping delivered-word count per lane.
module egress_scheduler #(
    parameter int TAMANO_DATOS = 12,
    parameter int BURST        = 4,
    parameter int CNT_W        = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    egress_scheduler_if.master   bus,
    output logic [4*CNT_W-1:0]   pkt_cnt,
    output logic                 idle
);
    localparam int W = TAMANO_DATOS;
    localparam logic [3:0] BURST_LIM = 4'(BURST);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t      state;
    logic [1:0]  grant;
    logic [3:0]  burst_cnt;
    logic [3:0]  pop_q;
    logic [1:0]  pop_lane_q;

    logic [W-1:0] skid_data [2];
    logic [1:0]   skid_lane [2];
    logic [1:0]   occ;

    logic [CNT_W-1:0] cnt [4];

    logic         inflight;
    logic         out_valid_int;
    logic         deq;
    logic [2:0]   load;
    logic         credit;
    logic [3:0]   eligible;
    logic [2:0]   rot;
    logic         rot_found;
    logic [1:0]   rot_lane;
    logic         burst_done;
    logic [W-1:0] cap_word;

    // First eligible lane in the order from+1, from+2, from+3, from (mod 4);
    // bit 2 flags whether any lane was found.
    function automatic logic [2:0] search(input logic [1:0] from, input logic [3:0] elig);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = from + 2'(k);
            if (elig[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign inflight      = |pop_q;
    assign out_valid_int = (occ != 2'd0);
    assign deq           = out_valid_int & bus.out_ready;
    assign load          = 3'(occ) + 3'(inflight) - 3'(deq);
    assign credit        = (load < 3'd2);
    assign rot           = search(grant, eligible);
    assign rot_found     = rot[2];
    assign rot_lane      = rot[1:0];
    assign burst_done    = (burst_cnt >= BURST_LIM);
    assign cap_word      = bus.fifo_data[32'(pop_lane_q)*W +: W];

    assign bus.pop       = pop_q;
    assign bus.out_valid = out_valid_int;
    assign bus.data_out  = skid_data[0];
    assign bus.out_lane  = skid_lane[0];

    assign idle = (state == IDLE) && (occ == 2'd0) && !inflight;

    // A lane that is being popped on its last word is masked, because its empty flag only drops after the pop lands.
    always_comb begin
        eligible = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            eligible[i] = !bus.empty[i] && !(pop_q[i] && bus.almost_empty[i]);
        end
    end

    // Grant FSM: pops are registered, IDLE only picks a lane, ACTIVE pops and rotates on burst expiry or an ineligible grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 2'd3;
            burst_cnt  <= 4'd0;
            pop_q      <= 4'b0000;
            pop_lane_q <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    pop_q <= 4'b0000;
                    if (rot_found && credit) begin
                        grant     <= rot_lane;
                        burst_cnt <= 4'd0;
                        state     <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (!rot_found) begin
                        pop_q     <= 4'b0000;
                        burst_cnt <= 4'd0;
                        state     <= IDLE;
                    end else if (burst_done || !eligible[grant]) begin
                        grant      <= rot_lane;
                        pop_lane_q <= rot_lane;
                        pop_q      <= credit ? (4'b0001 << rot_lane) : 4'b0000;
                        burst_cnt  <= credit ? 4'd1 : 4'd0;
                    end else begin
                        pop_lane_q <= grant;
                        pop_q      <= credit ? (4'b0001 << grant) : 4'b0000;
                        if (credit) begin
                            burst_cnt <= burst_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    pop_q <= 4'b0000;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Skid buffer: captures the word of last cycle's pop, slot 0 is the head and holds still while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ          <= 2'd0;
            skid_data[0] <= '0;
            skid_data[1] <= '0;
            skid_lane[0] <= 2'd0;
            skid_lane[1] <= 2'd0;
        end else begin
            case ({inflight, deq})
                2'b10: begin
                    if (occ == 2'd0) begin
                        skid_data[0] <= cap_word;
                        skid_lane[0] <= pop_lane_q;
                    end else begin
                        skid_data[1] <= cap_word;
                        skid_lane[1] <= pop_lane_q;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    skid_data[0] <= skid_data[1];
                    skid_lane[0] <= skid_lane[1];
                    occ          <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        skid_data[0] <= cap_word;
                        skid_lane[0] <= pop_lane_q;
                    end else begin
                        skid_data[0] <= skid_data[1];
                        skid_lane[0] <= skid_lane[1];
                        skid_data[1] <= cap_word;
                        skid_lane[1] <= pop_lane_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Per-lane delivered-word counters, wrapping freely.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else if (deq) begin
            cnt[skid_lane[0]] <= cnt[skid_lane[0]] + 1'b1;
        end
    end

    // Flatten the counters onto the output bus, lane i at [i*CNT_W +: CNT_W].
    always_comb begin
        pkt_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            pkt_cnt[i*CNT_W +: CNT_W] = cnt[i];
        end
    end
endmodule

// File: tb/tb_egress_scheduler.sv
// Bench for egress_scheduler: lane FIFOs and a per-lane scoreboard of loaded
// words live in queues; every cycle the outputs are compared against that model.
module tb_egress_scheduler;
    localparam int W     = 12;
    localparam int BURST = 4;
    localparam int CNT_W = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [4*CNT_W-1:0] pkt_cnt;
    logic idle;

    always #5 clk = ~clk;

    egress_scheduler_if #(.TAMANO_DATOS(W)) bus ();

    egress_scheduler #(
        .TAMANO_DATOS(W),
        .BURST(BURST),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .pkt_cnt(pkt_cnt),
        .idle(idle)
    );

    int tests_run = 0;
    int tests_failed = 0;

    logic [W-1:0] lane_q [4][$];
    logic [W-1:0] sent_q [4][$];
    int model_occ = 0;
    int cnt_model [4] = '{0, 0, 0, 0};
    int cyc = 0;
    int seq = 0;
    int pops_seen = 0;
    int total_loaded = 0;
    int total_delivered = 0;
    bit rst_drv = 1'b1;
    bit rst_prev = 1'b0;
    bit ready_drv = 1'b1;

    logic [3:0]   pop_tr [$];
    logic         val_tr [$];
    int           dlv_lane [$];
    int           dlv_cyc [$];
    logic [W-1:0] dlv_data [$];

    logic         hold_prev = 1'b0;
    logic [W-1:0] data_prev = '0;
    logic [1:0]   lane_prev = 2'd0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int l);
        return 32'(pkt_cnt[l*CNT_W +: CNT_W]);
    endfunction

    function automatic logic [3:0] get_pop(input int i);
        if (i >= 0 && i < pop_tr.size()) return pop_tr[i];
        return 4'hF;
    endfunction

    function automatic logic get_val(input int i);
        if (i >= 0 && i < val_tr.size()) return val_tr[i];
        return 1'bx;
    endfunction

    function automatic int first_pop();
        for (int i = 0; i < pop_tr.size(); i++) begin
            if (pop_tr[i] != 4'b0000) return i;
        end
        return -1;
    endfunction

    // One clock cycle: drive the FIFO view, check outputs against the model, then account for pops and deliveries.
    task automatic applyStimulus();
        int l;
        @(negedge clk);
        cyc++;
        if (rst_prev) begin
            checkOutput("rst_pop", 32'(bus.pop), 32'd0);
            checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
            checkOutput("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
            checkOutput("rst_idle", 32'(idle), 32'd1);
            checkOutput("rst_data_out", 32'(bus.data_out), 32'd0);
            checkOutput("rst_out_lane", 32'(bus.out_lane), 32'd0);
        end
        reset = rst_drv;
        bus.out_ready = ready_drv;
        for (int i = 0; i < 4; i++) begin
            bus.empty[i] = (lane_q[i].size() == 0);
            bus.almost_empty[i] = (lane_q[i].size() == 1);
            bus.fifo_data[i*W +: W] = (lane_q[i].size() > 0) ? lane_q[i][0] : '0;
        end
        if (rst_drv) begin
            for (int i = 0; i < 4; i++) begin
                lane_q[i].delete();
                sent_q[i].delete();
                cnt_model[i] = 0;
            end
            model_occ = 0;
            hold_prev = 1'b0;
        end else begin
            pop_tr.push_back(bus.pop);
            val_tr.push_back(bus.out_valid);
            checkOutput("pop_onehot", 32'($countones(bus.pop) <= 1), 32'd1);
            checkOutput("valid_vs_model", 32'(bus.out_valid), 32'(model_occ != 0));
            if (model_occ > 0 || bus.pop != 4'b0000) begin
                checkOutput("idle_busy", 32'(idle), 32'd0);
            end
            if (hold_prev) begin
                checkOutput("hold_data", 32'(bus.data_out), 32'(data_prev));
                checkOutput("hold_lane", 32'(bus.out_lane), 32'(lane_prev));
            end
            for (int i = 0; i < 4; i++) begin
                checkOutput("pkt_cnt", cnt_of(i), 32'(cnt_model[i] % (1 << CNT_W)));
            end
            if (bus.out_valid && bus.out_ready) begin
                l = int'(bus.out_lane);
                checkOutput("deliver_known", 32'(sent_q[l].size() > 0), 32'd1);
                if (sent_q[l].size() > 0) begin
                    checkOutput("deliver_data", 32'(bus.data_out), 32'(sent_q[l].pop_front()));
                end
                cnt_model[l]++;
                model_occ--;
                total_delivered++;
                dlv_lane.push_back(l);
                dlv_cyc.push_back(cyc);
                dlv_data.push_back(bus.data_out);
            end
            for (int i = 0; i < 4; i++) begin
                if (bus.pop[i]) begin
                    checkOutput("pop_nonempty", 32'(lane_q[i].size() > 0), 32'd1);
                    if (lane_q[i].size() > 0) void'(lane_q[i].pop_front());
                    model_occ++;
                    pops_seen++;
                end
            end
            checkOutput("occ_bound", 32'(model_occ <= 2), 32'd1);
            hold_prev = bus.out_valid && !bus.out_ready;
            data_prev = bus.data_out;
            lane_prev = bus.out_lane;
        end
        rst_prev = rst_drv;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic loadLane(input int l, input int n);
        logic [W-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = {2'($urandom_range(0, 3)), 2'(l), 8'(seq)};
            seq++;
            lane_q[l].push_back(w);
            sent_q[l].push_back(w);
            total_loaded++;
        end
    endtask

    task automatic applyReset();
        rst_drv = 1'b1;
        runCycles(2);
        rst_drv = 1'b0;
        applyStimulus();
    endtask

    task automatic clearTraces();
        pop_tr.delete();
        val_tr.delete();
        dlv_lane.delete();
        dlv_cyc.delete();
        dlv_data.delete();
        pops_seen = 0;
    endtask

    task automatic drain(input int max_cycles);
        int k;
        int pending;
        k = 0;
        pending = 1;
        while (k < max_cycles && pending != 0) begin
            applyStimulus();
            k++;
            pending = model_occ;
            for (int i = 0; i < 4; i++) pending += sent_q[i].size();
        end
        checkOutput("drain_done", 32'(pending), 32'd0);
        runCycles(2);
    endtask

    logic [W-1:0] exp_words [$];
    int f;
    int expect_lane;
    int loaded_before;

    initial begin
        bus.empty = 4'hF;
        bus.almost_empty = 4'h0;
        bus.fifo_data = '0;
        bus.out_ready = 1'b1;

        // T1: reset in the middle of traffic
        applyReset();
        for (int i = 0; i < 4; i++) loadLane(i, 3);
        runCycles(6);
        applyReset();

        // T2: single lane, three words
        clearTraces();
        loadLane(2, 3);
        exp_words = sent_q[2];
        drain(50);
        f = first_pop();
        checkOutput("t2_pop0", 32'(get_pop(f)), 32'h4);
        checkOutput("t2_pop1", 32'(get_pop(f + 1)), 32'h4);
        checkOutput("t2_pop2", 32'(get_pop(f + 2)), 32'h4);
        checkOutput("t2_pop3", 32'(get_pop(f + 3)), 32'h0);
        checkOutput("t2_valid_at_pop", 32'(get_val(f)), 32'd0);
        checkOutput("t2_valid_latency", 32'(get_val(f + 1)), 32'd1);
        checkOutput("t2_dlv_count", 32'(dlv_data.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t2_word", 32'((i < dlv_data.size()) ? dlv_data[i] : 'x), 32'(exp_words[i]));
            checkOutput("t2_lane", 32'((i < dlv_lane.size()) ? dlv_lane[i] : -1), 32'd2);
        end
        checkOutput("t2_pkt_cnt2", cnt_of(2), 32'd3);
        checkOutput("t2_idle", 32'(idle), 32'd1);

        // T3: burst rotation over four full lanes
        applyReset();
        clearTraces();
        for (int i = 0; i < 4; i++) loadLane(i, 6);
        drain(200);
        checkOutput("t3_dlv_count", 32'(dlv_lane.size()), 32'd24);
        for (int k = 0; k < 24; k++) begin
            expect_lane = (k < 16) ? (k / 4) : ((k - 16) / 2);
            checkOutput("t3_lane_order", 32'((k < dlv_lane.size()) ? dlv_lane[k] : -1), 32'(expect_lane));
        end
        checkOutput("t3_no_gaps", 32'((dlv_cyc.size() == 24) ? (dlv_cyc[23] - dlv_cyc[0]) : -1), 32'd23);

        // T4: backpressure with lane 1 full
        applyReset();
        ready_drv = 1'b0;
        loadLane(1, 6);
        clearTraces();
        runCycles(5);
        checkOutput("t4_pops_stalled", 32'(pops_seen), 32'd2);
        checkOutput("t4_pop_idle", 32'(get_pop(4)), 32'h0);
        checkOutput("t4_valid_held", 32'(bus.out_valid), 32'd1);
        ready_drv = 1'b1;
        drain(100);
        checkOutput("t4_dlv_count", 32'(dlv_data.size()), 32'd6);
        checkOutput("t4_pkt_cnt1", cnt_of(1), 32'd6);

        // T5: last-word guard moves the grant
        applyReset();
        clearTraces();
        loadLane(0, 1);
        loadLane(3, 2);
        drain(50);
        f = first_pop();
        checkOutput("t5_pop_lane0", 32'(get_pop(f)), 32'h1);
        checkOutput("t5_pop_lane3a", 32'(get_pop(f + 1)), 32'h8);
        checkOutput("t5_pop_lane3b", 32'(get_pop(f + 2)), 32'h8);
        checkOutput("t5_pop_done", 32'(get_pop(f + 3)), 32'h0);

        // T6: counter wrap on lane 1
        applyReset();
        loadLane(1, 33);
        drain(300);
        checkOutput("t6_pkt_cnt1_wrap", cnt_of(1), 32'd1);
        checkOutput("t6_pkt_cnt0", cnt_of(0), 32'd0);

        // Random traffic with random backpressure
        applyReset();
        loaded_before = total_loaded;
        total_delivered = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) loadLane(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
            ready_drv = ($urandom_range(0, 3) != 0);
            applyStimulus();
        end
        ready_drv = 1'b1;
        drain(600);
        checkOutput("rand_all_delivered", 32'(total_delivered), 32'(total_loaded - loaded_before));
        checkOutput("rand_idle", 32'(idle), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
